avalon_rect_fill_master: RTL
============================

Name: avalon_rect_fill_master

Overview:
- CSR-programmable Avalon-MM write master that fills a rectangular region of SDRAM frame memory with a pattern.
- Parametrised successor of the fixed full-screen solid-colour filler.
- Adds programmable base address, width, height and line stride, four pattern modes, start/abort control, done status and interrupt.
- Sits between the PCIe-driven Avalon slave fabric (CSR side) and the SDRAM controller that the pixel buffer scans.

Parameters:
- MASTER_ADDRESSWIDTH, 32, master byte-address width.
- DATAWIDTH, 32, master and slave data width; one pixel per word.
- SLAVE_ADDRESSWIDTH, 3, CSR word-address width (8 registers).
- DIMWIDTH, 16, width of the X/Y counters and the WIDTH/HEIGHT fields.
- CHECK_LOG2, 3, log2 of the checker tile size in pixels.
- DEFAULT_BASE, 32'h08000000, reset value of BASE.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- slave_address  in  SLAVE_ADDRESSWIDTH  CSR word index.
- slave_writedata  in  DATAWIDTH  CSR write data.
- slave_write  in  1  CSR write strobe.
- slave_read  in  1  CSR read strobe.
- slave_chipselect  in  1  qualifies slave_write and slave_read.
- slave_readdata  out  DATAWIDTH  CSR read data, registered.
- master_address  out  MASTER_ADDRESSWIDTH  byte address of the current pixel.
- master_writedata  out  DATAWIDTH  pixel value.
- master_write  out  1  write request.
- master_read  out  1  tied 0.
- master_waitrequest  in  1  slave stall.
- busy  out  1  fill in progress.
- irq  out  1  level-high while DONE and IRQ_EN are both set.

Behaviour:

CSR map (access is qualified by chipselect):
- 0 CTRL: bit0 START (write-1 pulse, reads 0), bit1 ABORT (write-1 pulse, reads 0), bits[3:2] MODE, bit4 IRQ_EN.
- 1 STATUS: bit0 BUSY (RO), bit1 DONE (sticky; cleared by writing 1, or by START), bit2 ABORTED (sticky; cleared with DONE).
- 2 BASE.
- 3 DIM: [DIMWIDTH-1:0] = WIDTH in pixels, [DIMWIDTH+15:16] = HEIGHT.
- 4 STRIDE in bytes.
- 5 COLOR0.
- 6 COLOR1.
- 7 COUNT (RO): pixels accepted in the current or last fill.

CSR timing and reset:
- Read latency is 1 cycle: slave_readdata is updated on the clock edge after slave_read && slave_chipselect, and holds otherwise.
- Writes to registers 2–6 while BUSY are ignored. Configuration is sampled only at START.
- Reset values: all registers 0 except BASE=DEFAULT_BASE. Outputs slave_readdata=0, master_write=0, master_address=0, master_writedata=0, busy=0, irq=0.

FSM states:
- IDLE:
  - START with WIDTH=0 or HEIGHT=0: no writes; DONE=1 on the next cycle; stay in IDLE.
  - Otherwise: latch the config, set x=0, y=0, row_base=BASE, COUNT=0, clear DONE and ABORTED, go to WRITE. master_write rises on the next cycle.
- WRITE:
  - master_write=1, master_address = row_base + 4*x, master_writedata = pattern(x,y).
  - Address arithmetic is modulo 2^MASTER_ADDRESSWIDTH; wrap-around is allowed and not flagged.
  - While master_waitrequest=1: address, data and write are held stable and nothing advances.
  - On accept (master_waitrequest=0): COUNT++.
  - If x==WIDTH-1: x=0, y++, row_base += STRIDE.
  - Else: x++.
  - If the accepted pixel is (WIDTH-1, HEIGHT-1): go to IDLE and set DONE=1.
- Exactly one write is accepted per cycle at most, giving a sustained rate of 1 pixel/cycle with no stalls.

Patterns (MODE):
- 0: COLOR0.
- 1: checker — COLOR1 if bit CHECK_LOG2 of (x XOR y) is 1, else COLOR0.
- 2: row stripes — COLOR1 on odd y, else COLOR0.
- 3: ramp — COLOR0 + x, truncated to DATAWIDTH.

Boundary cases:
- START while BUSY: ignored.
- ABORT while BUSY: takes effect at the next accept, or immediately if master_write is not yet stalled. The in-flight write is never retracted. Then go to IDLE with DONE=1 and ABORTED=1.
- START and ABORT in the same write: ABORT wins when BUSY; START wins when IDLE.
- ABORT while IDLE: no effect.
- reset mid-fill: master_write=0 in the cycle after the reset edge; all state returns to reset values.
- busy = (state==WRITE).

Test Plan:
- BASE=0x08000000, WIDTH=640, HEIGHT=480, STRIDE=2560, MODE=0, COLOR0=0x00FF0000, START, no stalls -> 307200 writes, all data 0x00FF0000, last address 0x0812BFFC, COUNT=307200, DONE=1; irq=1 only if IRQ_EN=1.
- WIDTH=4, HEIGHT=3, STRIDE=0x1000, BASE=0x100 -> addresses 0x100, 0x104, 0x108, 0x10C, 0x1100…0x110C, 0x2100…0x210C in order; DONE after the 12th accept.
- MODE=1, CHECK_LOG2=3, COLOR0=0xA, COLOR1=0xB, WIDTH=16, HEIGHT=9 -> row 0: x0–7 = 0xA, x8–15 = 0xB; row 8: x0–7 = 0xB. MODE=3 with COLOR0=0x10 -> data 0x10…0x1F per row.
- Assert waitrequest for 5 cycles on the 3rd pixel -> address/data/write stable for all 6 cycles, COUNT stays 2 until accept; START issued during the stall is ignored; a write to BASE during the stall leaves BASE unchanged.
- WIDTH=0 START -> zero master writes, DONE=1 one cycle later. ABORT after 10 accepts with waitrequest high -> the stalled write completes, COUNT=11, DONE=1, ABORTED=1.
- Reset asserted mid-fill -> master_write=0 and busy=0 next cycle, BASE=0x08000000, STATUS reads 0.

Source files
------------

// File: rtl/avalon_rect_fill_master.sv
// CSR-programmed Avalon-MM write master filling a rectangle of frame memory with a pattern.
// Latency: first write one cycle after START, then one pixel per accepted cycle; CSR reads one cycle.
// Backpressure: master_waitrequest freezes address/data/write and all progress until the write is accepted.
module avalon_rect_fill_master #(
    parameter int MASTER_ADDRESSWIDTH = 32,
    parameter int DATAWIDTH = 32,
    parameter int SLAVE_ADDRESSWIDTH = 3,
    parameter int DIMWIDTH = 16,
    parameter int CHECK_LOG2 = 3,
    parameter logic [MASTER_ADDRESSWIDTH-1:0] DEFAULT_BASE = 32'h08000000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [SLAVE_ADDRESSWIDTH-1:0]  slave_address,
    input  logic [DATAWIDTH-1:0]           slave_writedata,
    input  logic                           slave_write,
    input  logic                           slave_read,
    input  logic                           slave_chipselect,
    output logic [DATAWIDTH-1:0]           slave_readdata,
    output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
    output logic [DATAWIDTH-1:0]           master_writedata,
    output logic                           master_write,
    output logic                           master_read,
    input  logic                           master_waitrequest,
    output logic                           busy,
    output logic                           irq
);

    localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_CTRL   = SLAVE_ADDRESSWIDTH'(0);
    localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_STATUS = SLAVE_ADDRESSWIDTH'(1);
    localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_BASE   = SLAVE_ADDRESSWIDTH'(2);
    localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_DIM    = SLAVE_ADDRESSWIDTH'(3);
    localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_STRIDE = SLAVE_ADDRESSWIDTH'(4);
    localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_COLOR0 = SLAVE_ADDRESSWIDTH'(5);
    localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_COLOR1 = SLAVE_ADDRESSWIDTH'(6);
    localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_COUNT  = SLAVE_ADDRESSWIDTH'(7);

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t                         state_q, state_d;
    logic [1:0]                     mode_q, mode_d;
    logic                           irq_en_q, irq_en_d;
    logic [1:0]                     run_mode_q, run_mode_d;
    logic                           done_q, done_d;
    logic                           aborted_q, aborted_d;
    logic                           abort_pend_q, abort_pend_d;
    logic [MASTER_ADDRESSWIDTH-1:0] base_q, base_d;
    logic [DIMWIDTH-1:0]            width_q, width_d;
    logic [DIMWIDTH-1:0]            height_q, height_d;
    logic [DATAWIDTH-1:0]           stride_q, stride_d;
    logic [DATAWIDTH-1:0]           color0_q, color0_d;
    logic [DATAWIDTH-1:0]           color1_q, color1_d;
    logic [DATAWIDTH-1:0]           count_q, count_d;
    logic [DIMWIDTH-1:0]            x_q, x_d;
    logic [DIMWIDTH-1:0]            y_q, y_d;
    logic [MASTER_ADDRESSWIDTH-1:0] row_base_q, row_base_d;
    logic                           master_write_q, master_write_d;
    logic [MASTER_ADDRESSWIDTH-1:0] master_address_q, master_address_d;
    logic [DATAWIDTH-1:0]           master_writedata_q, master_writedata_d;
    logic [DATAWIDTH-1:0]           slave_readdata_q, slave_readdata_d;

    logic                           csr_wr, csr_rd, wr_ctrl, start_req, abort_req;
    logic                           accept, abort_now, x_last, y_last;
    logic [DIMWIDTH-1:0]            nx, ny;
    logic [MASTER_ADDRESSWIDTH-1:0] nrb;
    logic [DATAWIDTH-1:0]           rd_mux;

    function automatic logic [DATAWIDTH-1:0] pattern(
        input logic [1:0]           m,
        input logic [DIMWIDTH-1:0]  px,
        input logic [DIMWIDTH-1:0]  py,
        input logic [DATAWIDTH-1:0] c0,
        input logic [DATAWIDTH-1:0] c1
    );
        logic [DIMWIDTH-1:0] t;
        t = px ^ py;
        case (m)
            2'd0:    return c0;
            2'd1:    return t[CHECK_LOG2] ? c1 : c0;
            2'd2:    return py[0] ? c1 : c0;
            default: return c0 + DATAWIDTH'(px);
        endcase
    endfunction

    assign csr_wr    = slave_chipselect & slave_write;
    assign csr_rd    = slave_chipselect & slave_read;
    assign wr_ctrl   = csr_wr && (slave_address == A_CTRL);
    assign start_req = wr_ctrl & slave_writedata[0];
    assign abort_req = wr_ctrl & slave_writedata[1];
    assign accept    = (state_q == S_WRITE) & ~master_waitrequest;
    assign abort_now = abort_pend_q | abort_req;

    // Next pixel position in raster order, used when the current write is accepted.
    assign x_last = (x_q == width_q - DIMWIDTH'(1));
    assign y_last = (y_q == height_q - DIMWIDTH'(1));
    assign nx     = x_last ? '0 : x_q + DIMWIDTH'(1);
    assign ny     = x_last ? y_q + DIMWIDTH'(1) : y_q;
    assign nrb    = x_last ? row_base_q + MASTER_ADDRESSWIDTH'(stride_q) : row_base_q;

    always_comb begin
        rd_mux = '0;
        case (slave_address)
            A_CTRL:   rd_mux[4:2] = {irq_en_q, mode_q};
            A_STATUS: rd_mux[2:0] = {aborted_q, done_q, busy};
            A_BASE:   rd_mux = DATAWIDTH'(base_q);
            A_DIM: begin
                rd_mux[DIMWIDTH-1:0]  = width_q;
                rd_mux[16 +: DIMWIDTH] = height_q;
            end
            A_STRIDE: rd_mux = stride_q;
            A_COLOR0: rd_mux = color0_q;
            A_COLOR1: rd_mux = color1_q;
            A_COUNT:  rd_mux = count_q;
            default:  rd_mux = '0;
        endcase
    end

    always_comb begin
        state_d            = state_q;
        mode_d             = mode_q;
        irq_en_d           = irq_en_q;
        run_mode_d         = run_mode_q;
        done_d             = done_q;
        aborted_d          = aborted_q;
        abort_pend_d       = abort_pend_q;
        base_d             = base_q;
        width_d            = width_q;
        height_d           = height_q;
        stride_d           = stride_q;
        color0_d           = color0_q;
        color1_d           = color1_q;
        count_d            = count_q;
        x_d                = x_q;
        y_d                = y_q;
        row_base_d         = row_base_q;
        master_write_d     = master_write_q;
        master_address_d   = master_address_q;
        master_writedata_d = master_writedata_q;
        slave_readdata_d   = csr_rd ? rd_mux : slave_readdata_q;

        if (wr_ctrl) begin
            mode_d   = slave_writedata[3:2];
            irq_en_d = slave_writedata[4];
        end
        if (csr_wr && slave_address == A_STATUS && slave_writedata[1]) begin
            done_d    = 1'b0;
            aborted_d = 1'b0;
        end
        // Geometry and colours are frozen for the whole fill.
        if (csr_wr && state_q == S_IDLE) begin
            case (slave_address)
                A_BASE:   base_d = MASTER_ADDRESSWIDTH'(slave_writedata);
                A_DIM: begin
                    width_d  = slave_writedata[DIMWIDTH-1:0];
                    height_d = slave_writedata[16 +: DIMWIDTH];
                end
                A_STRIDE: stride_d = slave_writedata;
                A_COLOR0: color0_d = slave_writedata;
                A_COLOR1: color1_d = slave_writedata;
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    done_d       = 1'b0;
                    aborted_d    = 1'b0;
                    abort_pend_d = 1'b0;
                    count_d      = '0;
                    if (width_q == '0 || height_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        run_mode_d         = slave_writedata[3:2];
                        x_d                = '0;
                        y_d                = '0;
                        row_base_d         = base_q;
                        master_write_d     = 1'b1;
                        master_address_d   = base_q;
                        master_writedata_d = pattern(slave_writedata[3:2], '0, '0,
                                                     color0_q, color1_q);
                        state_d            = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (accept) begin
                    count_d = count_q + DATAWIDTH'(1);
                    if ((x_last && y_last) || abort_now) begin
                        state_d        = S_IDLE;
                        master_write_d = 1'b0;
                        done_d         = 1'b1;
                        aborted_d      = abort_now;
                        abort_pend_d   = 1'b0;
                    end else begin
                        x_d                = nx;
                        y_d                = ny;
                        row_base_d         = nrb;
                        master_address_d   = nrb + MASTER_ADDRESSWIDTH'({nx, 2'b00});
                        master_writedata_d = pattern(run_mode_q, nx, ny, color0_q, color1_q);
                    end
                end else if (abort_req) begin
                    abort_pend_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= S_IDLE;
            mode_q             <= '0;
            irq_en_q           <= 1'b0;
            run_mode_q         <= '0;
            done_q             <= 1'b0;
            aborted_q          <= 1'b0;
            abort_pend_q       <= 1'b0;
            base_q             <= DEFAULT_BASE;
            width_q            <= '0;
            height_q           <= '0;
            stride_q           <= '0;
            color0_q           <= '0;
            color1_q           <= '0;
            count_q            <= '0;
            x_q                <= '0;
            y_q                <= '0;
            row_base_q         <= '0;
            master_write_q     <= 1'b0;
            master_address_q   <= '0;
            master_writedata_q <= '0;
            slave_readdata_q   <= '0;
        end else begin
            state_q            <= state_d;
            mode_q             <= mode_d;
            irq_en_q           <= irq_en_d;
            run_mode_q         <= run_mode_d;
            done_q             <= done_d;
            aborted_q          <= aborted_d;
            abort_pend_q       <= abort_pend_d;
            base_q             <= base_d;
            width_q            <= width_d;
            height_q           <= height_d;
            stride_q           <= stride_d;
            color0_q           <= color0_d;
            color1_q           <= color1_d;
            count_q            <= count_d;
            x_q                <= x_d;
            y_q                <= y_d;
            row_base_q         <= row_base_d;
            master_write_q     <= master_write_d;
            master_address_q   <= master_address_d;
            master_writedata_q <= master_writedata_d;
            slave_readdata_q   <= slave_readdata_d;
        end
    end

    assign slave_readdata   = slave_readdata_q;
    assign master_address   = master_address_q;
    assign master_writedata = master_writedata_q;
    assign master_write     = master_write_q;
    assign master_read      = 1'b0;
    assign busy             = (state_q == S_WRITE);
    assign irq              = done_q & irq_en_q;

endmodule
